// File: rtl/ccu_cmd_queue.sv
// Command FIFO feeding the CCU: it queues host opcodes and issues them one at a time,
// holding each until ccu_done. Define CMDQ_LEVEL_EN to expose the entry count on `level`.
module ccu_cmd_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  NOP_CODE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [7:0]               cmd,
  output logic                     cmd_valid,
  input  logic                     ccu_done,
  output logic                     busy
`ifdef CMDQ_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic          push, pop;

  assign in_ready = (count != FULL_CNT);
  assign busy     = (state == BUSY);

  // The registered count gates issue, so an entry pushed this cycle is only issuable next edge.
  assign push = in_valid && in_ready && !flush;
  assign pop  = !flush && (count != '0) && ((state == IDLE) || ccu_done);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cmd       <= NOP_CODE;
      cmd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cmd       <= NOP_CODE;
      cmd_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      cmd_valid <= pop;
      if (pop) begin
        cmd   <= mem[rd_ptr];
        state <= BUSY;
      end else if (state == BUSY && ccu_done) begin
        state <= IDLE;
      end
    end
  end

`ifdef CMDQ_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: doc/ccu_cmd_queue.md
Name: ccu_cmd_queue

Overview:
- Upstream feeder for the CCU.
- Buffers 8-bit command opcodes pushed by the host/bus side in a FIFO and issues them one at a time on the CCU `cmd` input.
- Holds each opcode stable until the CCU sequencer reports completion, so the CCU's 24-bit K control word is decoded from a steady opcode for the whole instruction.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- NOP_CODE, 8'h00, opcode driven on `cmd` after reset or flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous queue clear.
- in_valid  input  1  host offers opcode.
- in_data  input  8  host opcode.
- in_ready  output  1  queue can accept; = !full (combinational from count).
- cmd  output  8  opcode to CCU `cmd`; registered.
- cmd_valid  output  1  one-cycle pulse, first cycle of a new opcode on `cmd`.
- ccu_done  input  1  CCU finished current opcode (level or pulse, sampled in BUSY only).
- busy  output  1  high while an issued opcode is outstanding.
- level  output  $clog2(DEPTH)+1  entry count (only with CMDQ_LEVEL_EN).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; count=0; rd/wr pointers=0.
  - state=IDLE; cmd=NOP_CODE; cmd_valid=0; busy=0; in_ready=1.
  - Applies at any time, including mid-instruction; no partial issue survives.
- FIFO:
  - Push on edge when in_valid && in_ready; in_data written at wr_ptr, wr_ptr+1 mod DEPTH.
  - Pop on issue; rd_ptr+1 mod DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on both.
  - Full: count==DEPTH. Empty: count==0.
  - Push while full is dropped; count and pointers unchanged.
  - Push and pop in the same cycle while full: push still rejected, because in_ready is low that cycle.
  - Push into an empty queue: the entry is not issuable in the same cycle; earliest issue is the next edge.
  - Push-to-cmd_valid latency from an idle, empty queue: 2 edges.
- Issue FSM, states IDLE and BUSY:
  - IDLE, count>0:
    - At the edge: cmd <= head; cmd_valid <= 1; pop; busy <= 1; -> BUSY.
  - IDLE, count==0:
    - Hold cmd (last opcode or NOP_CODE); cmd_valid <= 0.
  - BUSY:
    - cmd_valid <= 0 after its single cycle; cmd held stable.
    - ccu_done && count>0: back-to-back issue at that edge. cmd <= head; cmd_valid <= 1; pop; stay BUSY.
    - ccu_done && count==0: -> IDLE; busy <= 0; cmd keeps last opcode.
    - ccu_done low: remain in BUSY indefinitely (no timeout).
  - ccu_done sampled in IDLE is ignored.
  - ccu_done high in the same cycle as cmd_valid counts as completion of the newly issued opcode.
  - Minimum opcode hold: 1 cycle.
- Flush, synchronous, highest priority after reset:
  - At the edge: count=0; pointers=0; state=IDLE; cmd=NOP_CODE; cmd_valid=0; busy=0.
  - A push in the same cycle is discarded.
  - ccu_done in the same cycle is ignored.
- Ordering: strict FIFO; no opcode is reordered, duplicated or skipped.
- Opcode values are passed through untouched; NOP_CODE pushed by the host is queued like any other.

Optional Feature:
- Macro: CMDQ_LEVEL_EN.
- Defined:
  - Port `level` exists and is driven from the count register.
  - Reset/flush value 0; range 0..DEPTH.
  - Updates on the edge of push/pop.
- Undefined:
  - Port `level` is absent.
  - Count remains internal; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0, release, run 5 clocks with no stimulus.
  - Required: cmd=8'h00, cmd_valid=0, busy=0, in_ready=1 throughout.
- Single issue:
  - Stimulus: push 8'd76 at edge 1; assert ccu_done for 1 cycle at edge 6.
  - Required: cmd=76 with cmd_valid pulse at edge 2; busy=1 edges 2..6; busy=0 after edge 6; cmd stays 76.
- Back-to-back:
  - Stimulus: push 76,75,73,70 consecutively; pulse ccu_done every 3rd cycle.
  - Required: cmd sequence 76,75,73,70; one cmd_valid per opcode, each on the done edge; no gaps; final busy=0.
- Full queue, DEPTH=8:
  - Stimulus: push 10 opcodes 1..10 with ccu_done held low.
  - Required: first opcode issued; in_ready low once count reaches 8; 10th push dropped; drain with done pulses yields 1..9, never 10.
- Flush mid-operation:
  - Stimulus: with 3 queued and BUSY, assert flush together with in_valid=1 and ccu_done=1.
  - Required: next cycle cmd=8'h00, busy=0, level=0, no cmd_valid; the pushed opcode is never issued.
- Asynchronous reset mid-BUSY:
  - Stimulus: drop rst_n between clock edges.
  - Required: outputs reach reset values before the next edge.
  - Required: with CMDQ_LEVEL_EN, level=0 immediately.
